// File: rtl/stage_mem.sv
// MEM pipeline stage for an 8-bit RAM port: each LOAD/STORE becomes 1, 2 or 4
// byte accesses to a 1-cycle-latency RAM while the upstream pipeline is stalled.
module stage_mem #(
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       store_data_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       wdata_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [31:0]       wdata_o,
  output logic              stall_req_o,
  output logic [31:0]       mem_a_o,
  output logic [BYTE_W-1:0] mem_dout_o,
  output logic              mem_wr_o,
  input  logic [BYTE_W-1:0] mem_din_i
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t                  state, state_nxt;
  logic [1:0]              cnt, cnt_nxt;
  logic                    is_load_q;
  logic [31:0]             addr_q, sdata_q;
  logic [2:0]              f3_q;
  logic [4:0]              wd_q;
  logic                    wreg_q;
  logic [3:0][BYTE_W-1:0]  bytes_q;
  logic                    cap_pend_q;
  logic [1:0]              cap_idx_q;

  logic                    is_mem, f3_legal, mem_op;
  logic [1:0]              last_idx;
  logic [31:0]             load_val;

  assign is_mem   = (opcode_i == OP_LOAD) || (opcode_i == OP_STORE);
  assign f3_legal = funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign mem_op   = is_mem && f3_legal;

  // Index of the final byte: B/BU -> 0, H/HU -> 1, W -> 3.
  always_comb begin
    case (f3_q[1:0])
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (rdy) begin
      case (state)
        IDLE: if (mem_op) begin
          state_nxt = ACCESS;
          cnt_nxt   = 2'd0;
        end
        ACCESS: begin
          if (cnt == last_idx) state_nxt = is_load_q ? WAIT : DONE;
          else                 cnt_nxt   = cnt + 2'd1;
        end
        WAIT:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      is_load_q  <= 1'b0;
      addr_q     <= '0;
      sdata_q    <= '0;
      f3_q       <= '0;
      wd_q       <= '0;
      wreg_q     <= 1'b0;
      bytes_q    <= '0;
      cap_pend_q <= 1'b0;
      cap_idx_q  <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && rdy && mem_op) begin
        is_load_q <= (opcode_i == OP_LOAD);
        addr_q    <= mem_addr_i;
        sdata_q   <= store_data_i;
        f3_q      <= funct3_i;
        wd_q      <= wd_i;
        wreg_q    <= wreg_i;
      end
      // A read issued in a running ACCESS cycle lands one edge later, even if rdy has dropped.
      cap_pend_q <= rdy && (state == ACCESS) && is_load_q;
      cap_idx_q  <= cnt;
      if (cap_pend_q) bytes_q[cap_idx_q] <= mem_din_i;
    end
  end

  always_comb begin
    case (f3_q)
      3'b000:  load_val = {{24{bytes_q[0][7]}}, bytes_q[0]};
      3'b100:  load_val = {24'h0, bytes_q[0]};
      3'b001:  load_val = {{16{bytes_q[1][7]}}, bytes_q[1], bytes_q[0]};
      3'b101:  load_val = {16'h0, bytes_q[1], bytes_q[0]};
      default: load_val = bytes_q;
    endcase
  end

  // Outputs are gated by rst so that asserting reset clears them without a clock.
  always_comb begin
    wd_o        = '0;
    wreg_o      = 1'b0;
    wdata_o     = '0;
    stall_req_o = 1'b0;
    mem_a_o     = '0;
    mem_dout_o  = '0;
    mem_wr_o    = 1'b0;
    if (rst) begin
      case (state)
        IDLE: begin
          if (!is_mem) begin
            wd_o    = wd_i;
            wreg_o  = wreg_i;
            wdata_o = wdata_i;
          end
          // Held even while paused so upstream never slips past a pending access.
          stall_req_o = mem_op;
        end
        ACCESS: begin
          stall_req_o = 1'b1;
          mem_a_o     = addr_q + {30'h0, cnt};
          if (!is_load_q) begin
            mem_dout_o = sdata_q[{cnt, 3'b000} +: BYTE_W];
            mem_wr_o   = rdy;
          end
        end
        WAIT: stall_req_o = 1'b1;
        default: begin
          if (is_load_q) begin
            wd_o    = wd_q;
            wreg_o  = wreg_q;
            wdata_o = load_val;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
// Bench for stage_mem: a byte RAM model with 1-cycle read latency, plus queues of
// expected writes and writeback results that are drained as the DUT produces them.
module tb_stage_mem;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ADD   = 7'b0110011;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    bit          chk_wd;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic [6:0]  opcode_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] mem_addr_i = '0, store_data_i = '0, wdata_i = '0;
  logic [4:0]  wd_i = '0;
  logic        wreg_i = 1'b0;
  logic [4:0]  wd_o;
  logic        wreg_o, stall_req_o, mem_wr_o;
  logic [31:0] wdata_o, mem_a_o;
  logic [7:0]  mem_dout_o;
  logic [7:0]  mem_din_i = '0;

  int n_checks = 0;
  int n_errors = 0;

  res_t res_q[$];
  wr_t  wr_q[$];
  logic [7:0] ram [logic [31:0]];

  always #5 clk = ~clk;

  stage_mem #(.BYTE_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .opcode_i     (opcode_i),
    .funct3_i     (funct3_i),
    .mem_addr_i   (mem_addr_i),
    .store_data_i (store_data_i),
    .wd_i         (wd_i),
    .wreg_i       (wreg_i),
    .wdata_i      (wdata_i),
    .wd_o         (wd_o),
    .wreg_o       (wreg_o),
    .wdata_o      (wdata_o),
    .stall_req_o  (stall_req_o),
    .mem_a_o      (mem_a_o),
    .mem_dout_o   (mem_dout_o),
    .mem_wr_o     (mem_wr_o),
    .mem_din_i    (mem_din_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // RAM model: request sampled mid-cycle, write and registered read applied at the edge.
  logic        st_wr = 1'b0;
  logic [31:0] st_a  = '0;
  logic [7:0]  st_d  = '0;

  always @(negedge clk) begin
    st_wr = mem_wr_o;
    st_a  = mem_a_o;
    st_d  = mem_dout_o;
    if (mem_wr_o) begin
      if (wr_q.size() == 0) begin
        check("write_unexpected", {31'h0, mem_wr_o}, 32'h0);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        check("write_addr", mem_a_o, w.a);
        check("write_data", {24'h0, mem_dout_o}, {24'h0, w.d});
      end
    end
  end

  always @(posedge clk) begin
    if (st_wr) ram[st_a] = st_d;
    mem_din_i <= ram.exists(st_a) ? ram[st_a] : 8'h00;
  end

  // Issue one instruction, follow it until stall_req_o drops, then score the result.
  task automatic run_op(input string name, input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                        input logic [4:0] exp_wd, input logic exp_wreg,
                        input logic [31:0] exp_wdata, input bit chk_wd,
                        input int pause_after, input int pause_len);
    int   n, exp_stall, act, stall_n, pause_left;
    bit   legal, done;
    res_t r;
    n     = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = (op == OP_LOAD || op == OP_STORE) && (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    if (!legal)            exp_stall = 0;
    else if (op == OP_LOAD) exp_stall = n + 2 + pause_len;
    else                   exp_stall = n + 1 + pause_len;
    if (legal && op == OP_STORE) begin
      for (int k = 0; k < n; k++) begin
        wr_t w;
        w.a = addr + 32'(k);
        w.d = sdata[8*k +: 8];
        wr_q.push_back(w);
      end
    end
    r.wd = exp_wd; r.wreg = exp_wreg; r.wdata = exp_wdata; r.chk_wd = chk_wd;
    res_q.push_back(r);

    @(posedge clk); #1;
    opcode_i = op; funct3_i = f3; mem_addr_i = addr; store_data_i = sdata;
    wd_i = wd; wreg_i = wreg; wdata_i = wdata; rdy = 1'b1;

    act = 0; stall_n = 0; pause_left = 0; done = 1'b0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      @(negedge clk);
      if (!stall_req_o) begin
        done = 1'b1;
        break;
      end
      stall_n++;
      if (rdy) begin
        if (act >= 1 && act <= n) check({name, ".addr"}, mem_a_o, addr + 32'(act - 1));
        if (act == pause_after) pause_left = pause_len;
        act++;
      end else begin
        check({name, ".wr_paused"}, {31'h0, mem_wr_o}, 32'h0);
      end
      @(posedge clk); #1;
      if (pause_left > 0) begin
        rdy = 1'b0;
        pause_left--;
      end else begin
        rdy = 1'b1;
      end
    end
    check({name, ".done"}, {31'h0, done}, 32'h1);
    check({name, ".stall_len"}, 32'(stall_n), 32'(exp_stall));
    r = res_q.pop_front();
    check({name, ".wreg"}, {31'h0, wreg_o}, {31'h0, r.wreg});
    check({name, ".wdata"}, wdata_o, r.wdata);
    if (r.chk_wd) check({name, ".wd"}, {27'h0, wd_o}, {27'h0, r.wd});
    check({name, ".writes_left"}, 32'(wr_q.size()), 32'h0);
  endtask

  initial begin
    ram[32'h100] = 8'h78; ram[32'h101] = 8'h56; ram[32'h102] = 8'h34; ram[32'h103] = 8'h12;
    ram[32'h10]  = 8'h80;
    ram[32'h20]  = 8'h00; ram[32'h21]  = 8'h80;
    for (int i = 0; i < 4; i++) ram[32'h300 + 32'(i)] = 8'h5A;

    // Reset held with a pass-through op on the inputs: every output must stay 0.
    opcode_i = OP_ADD; wd_i = 5'd9; wreg_i = 1'b1; wdata_i = 32'hCAFE_F00D;
    repeat (2) @(posedge clk);
    #1;
    check("rst.wd", {27'h0, wd_o}, 32'h0);
    check("rst.wreg", {31'h0, wreg_o}, 32'h0);
    check("rst.wdata", wdata_o, 32'h0);
    check("rst.stall", {31'h0, stall_req_o}, 32'h0);
    check("rst.mem_a", mem_a_o, 32'h0);
    check("rst.mem_wr", {31'h0, mem_wr_o}, 32'h0);
    #1 rst = 1'b1;

    run_op("add", OP_ADD, 3'b000, 32'h0, 32'h0, 5'd7, 1'b1, 32'h1234_ABCD,
           5'd7, 1'b1, 32'h1234_ABCD, 1'b1, -1, 0);
    run_op("lw", OP_LOAD, 3'b010, 32'h100, 32'h0, 5'd3, 1'b1, 32'h0,
           5'd3, 1'b1, 32'h1234_5678, 1'b1, -1, 0);
    run_op("lb", OP_LOAD, 3'b000, 32'h10, 32'h0, 5'd4, 1'b1, 32'h0,
           5'd4, 1'b1, 32'hFFFF_FF80, 1'b1, -1, 0);
    run_op("lbu", OP_LOAD, 3'b100, 32'h10, 32'h0, 5'd4, 1'b1, 32'h0,
           5'd4, 1'b1, 32'h0000_0080, 1'b1, -1, 0);
    run_op("lh", OP_LOAD, 3'b001, 32'h20, 32'h0, 5'd5, 1'b1, 32'h0,
           5'd5, 1'b1, 32'hFFFF_8000, 1'b1, -1, 0);
    run_op("lhu", OP_LOAD, 3'b101, 32'h20, 32'h0, 5'd5, 1'b1, 32'h0,
           5'd5, 1'b1, 32'h0000_8000, 1'b1, -1, 0);
    run_op("sh", OP_STORE, 3'b001, 32'h200, 32'hAABB_CCDD, 5'd6, 1'b1, 32'h55,
           5'd0, 1'b0, 32'h0, 1'b0, -1, 0);
    run_op("sw_wrap", OP_STORE, 3'b010, 32'hFFFF_FFFE, 32'h0102_0304, 5'd6, 1'b1, 32'h55,
           5'd0, 1'b0, 32'h0, 1'b0, -1, 0);
    run_op("lw_wrap", OP_LOAD, 3'b010, 32'hFFFF_FFFE, 32'h0, 5'd8, 1'b1, 32'h0,
           5'd8, 1'b1, 32'h0102_0304, 1'b1, -1, 0);
    run_op("lw_pause", OP_LOAD, 3'b010, 32'h100, 32'h0, 5'd3, 1'b1, 32'h0,
           5'd3, 1'b1, 32'h1234_5678, 1'b1, 2, 3);
    run_op("illegal_f3", OP_LOAD, 3'b011, 32'h100, 32'h0, 5'd5, 1'b1, 32'hDEAD_BEEF,
           5'd0, 1'b0, 32'h0, 1'b0, -1, 0);
    check("sh.ram200", {24'h0, ram[32'h200]}, 32'hDD);
    check("sh.ram201", {24'h0, ram[32'h201]}, 32'hCC);

    // Reset in the third byte of a word store: the write strobe must drop at once.
    begin
      wr_t w;
      w.a = 32'h300; w.d = 8'h44; wr_q.push_back(w);
      w.a = 32'h301; w.d = 8'h33; wr_q.push_back(w);
    end
    @(posedge clk); #1;
    opcode_i = OP_STORE; funct3_i = 3'b010; mem_addr_i = 32'h300;
    store_data_i = 32'h1122_3344; wd_i = 5'd1; wreg_i = 1'b1; wdata_i = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid.wr_before", {31'h0, mem_wr_o}, 32'h1);
    check("rst_mid.addr_before", mem_a_o, 32'h302);
    rst = 1'b0;
    #1;
    check("rst_mid.wr_after", {31'h0, mem_wr_o}, 32'h0);
    check("rst_mid.stall_after", {31'h0, stall_req_o}, 32'h0);
    check("rst_mid.mem_a_after", mem_a_o, 32'h0);
    opcode_i = OP_ADD;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    check("rst_mid.ram300", {24'h0, ram[32'h300]}, 32'h44);
    check("rst_mid.ram301", {24'h0, ram[32'h301]}, 32'h33);
    check("rst_mid.ram302", {24'h0, ram[32'h302]}, 32'h5A);
    check("rst_mid.ram303", {24'h0, ram[32'h303]}, 32'h5A);
    check("rst_mid.writes_left", 32'(wr_q.size()), 32'h0);
    run_op("add_after_rst", OP_ADD, 3'b000, 32'h0, 32'h0, 5'd12, 1'b1, 32'h0BAD_CAFE,
           5'd12, 1'b1, 32'h0BAD_CAFE, 1'b1, -1, 0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/stage_mem.md
STAGE_MEM -- requirements
Module: stage_mem

Interface
REQ-001 Parameter BYTE_W, default 8: width of the memory data port; fixed at 8, no other value is supported.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous reset, active-low (0 = reset asserted).
REQ-004 rdy  input  1  global ready; 1 = run, 0 = pause (FSM frozen, no memory write).
REQ-005 opcode_i  input  7  opcode from the EX/MEM register; LOAD = 0000011, STORE = 0100011.
REQ-006 funct3_i  input  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 mem_addr_i  input  32  effective address computed by EX.
REQ-008 store_data_i  input  32  rs2 value for stores.
REQ-009 wd_i / wreg_i / wdata_i  input  5/1/32  destination register, write enable, ALU result.
REQ-010 wd_o / wreg_o / wdata_o  output  5/1/32  writeback fields to the MEM/WB register.
REQ-011 stall_req_o  output  1  1 = hold PC, IF/ID, ID/EX and EX/MEM registers.
REQ-012 mem_a_o  output  32  byte address to RAM.
REQ-013 mem_dout_o  output  8  write byte.
REQ-014 mem_wr_o  output  1  1 = write mem_dout_o to mem_a_o at this clock edge.
REQ-015 mem_din_i  input  8  read byte; valid in the cycle after its address was driven (fixed 1-cycle read latency).

Function
REQ-016 States SHALL be IDLE, ACCESS, WAIT and DONE, with a byte counter cnt[1:0] and a latched copy of the op, address, size and data.
REQ-017 Size N SHALL be 1 for B/BU, 2 for H/HU and 4 for W; funct3 011, 110 or 111 with LOAD/STORE is illegal: no access, wreg_o=0, wdata_o=0, no stall.
REQ-018 IDLE, non-memory op: wd_o=wd_i, wreg_o=wreg_i, wdata_o=wdata_i combinationally; stall_req_o=0; mem_wr_o=0; mem_a_o=0.
REQ-019 IDLE, legal LOAD/STORE with rdy=1: stall_req_o=1 combinationally, latch the inputs, set cnt=0, next state ACCESS; no memory access occurs in this cycle.
REQ-020 ACCESS, cycle k (k = 0..N-1): mem_a_o = latched_addr + k, modulo 2^32 (wraps at 0xFFFFFFFF).
REQ-021 ACCESS, store: mem_wr_o=1 and mem_dout_o = store_data[8k+7:8k] (little-endian).
REQ-022 ACCESS, load: mem_wr_o=0; for k>=1, capture mem_din_i as byte k-1.
REQ-023 ACCESS exit: after k = N-1, a load goes to WAIT and a store goes to DONE.
REQ-024 WAIT: capture mem_din_i as byte N-1; mem_wr_o=0; next state DONE.
REQ-025 stall_req_o SHALL be 1 in the IDLE accept cycle, in ACCESS and in WAIT.
REQ-026 Stall length: a load stalls N+2 cycles and a store stalls N+1 cycles; DONE follows immediately.
REQ-027 DONE: stall_req_o=0, mem_wr_o=0, next state IDLE; upstream advances EX/MEM at the end of DONE.
REQ-028 DONE, load: wd_o=latched wd, wreg_o=latched wreg, wdata_o = assembled value.
REQ-029 Load extension: B sign-extends bit 7; BU zero-extends; H sign-extends bit 15; HU zero-extends; W is unmodified.
REQ-030 DONE, store: wreg_o=0, wdata_o=0.
REQ-031 ACCESS/WAIT: wreg_o=0, wd_o=0, wdata_o=0, so no partial result is ever forwarded.
REQ-032 rdy=0: state, cnt and captured bytes hold, except that a byte whose address was driven in the previous rdy=1 cycle is still captured.
REQ-033 rdy=0: mem_wr_o=0; mem_a_o holds its value.
REQ-034 rdy=0: stall_req_o keeps its state-based value; an IDLE memory op is not accepted until rdy=1.
REQ-035 Inputs SHALL be ignored from the accept cycle to DONE, since upstream holds them while stall_req_o=1.

Reset
REQ-036 rst=0 SHALL immediately force state=IDLE and cnt=0, independent of clk.
REQ-037 rst=0 SHALL immediately force all outputs to 0 (wd_o, wreg_o, wdata_o, stall_req_o, mem_a_o, mem_dout_o, mem_wr_o).
REQ-038 Reset mid-access SHALL abort with no further mem_wr_o pulses; bytes already written stay written.
REQ-039 After rst rises, the first rising edge is treated as IDLE.

Verification
REQ-040 LW, addr 0x100, RAM[0x100..0x103] = 78 56 34 12 -> mem_a_o 0x100..0x103 in consecutive cycles; stall_req_o=1 for 6 cycles; DONE shows wdata_o=0x12345678 with wreg_o=1.
REQ-041 LB, RAM byte 0x80 -> wdata_o=0xFFFFFF80; LBU -> 0x00000080; LH of bytes 00 80 -> 0xFFFF8000; LHU -> 0x00008000.
REQ-042 SH, addr 0x200, store_data 0xAABBCCDD -> exactly 2 mem_wr_o pulses (0x200<-DD, 0x201<-CC); stall 3 cycles; DONE shows wreg_o=0.
REQ-043 SW at 0xFFFFFFFE -> mem_a_o FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-044 LW with rdy=0 for 3 cycles after cnt=1 -> mem_wr_o stays 0; same final value as REQ-040; stall extended by exactly 3 cycles.
REQ-045 Async reset during SW after byte 1 -> mem_wr_o falls without waiting for clk; no further writes; next ADD passes wdata_i through with stall_req_o=0.
